// File: rtl/case_item_match_engine_if.sv
// Handshake bundle for the case-item match engine: start beat, item stream and result.
// The engine attaches through the slave modport, the driver through the master modport.
interface case_item_match_engine_if #(
    parameter int MAXW = 32,
    parameter int WW   = 6,
    parameter int IDXW = 8
);
    logic            start_valid;
    logic            start_ready;
    logic [MAXW-1:0] sel_value;
    logic [WW-1:0]   sel_width;
    logic            sel_signed;
    logic [WW-1:0]   ctx_width;
    logic            ctx_signed;

    logic            item_valid;
    logic            item_ready;
    logic [MAXW-1:0] item_value;
    logic [WW-1:0]   item_width;
    logic            item_signed;
    logic            item_default;
    logic            item_last;

    logic            res_valid;
    logic            res_ready;
    logic            res_match;
    logic            res_dflt;
    logic [IDXW-1:0] res_index;
    logic            res_err;

    modport master (
        output start_valid, sel_value, sel_width, sel_signed, ctx_width, ctx_signed,
        output item_valid, item_value, item_width, item_signed, item_default, item_last,
        output res_ready,
        input  start_ready, item_ready,
        input  res_valid, res_match, res_dflt, res_index, res_err
    );

    modport slave (
        input  start_valid, sel_value, sel_width, sel_signed, ctx_width, ctx_signed,
        input  item_valid, item_value, item_width, item_signed, item_default, item_last,
        input  res_ready,
        output start_ready, item_ready,
        output res_valid, res_match, res_dflt, res_index, res_err
    );
endinterface

// File: rtl/case_item_match_engine.sv
// Run-time case-statement evaluator: latches a selector, scans item beats and reports the
// first matching item (or the default) using context-width, all-signed-or-zero extension.
module case_item_match_engine #(
    parameter int MAXW = 32,
    parameter int WW   = 6,
    parameter int IDXW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    case_item_match_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t          r_state, w_next;
    logic [MAXW-1:0] r_sel;
    logic [WW-1:0]   r_ctx_w;
    logic            r_ctx_s;
    logic            r_sel_bad;
    logic [IDXW-1:0] r_cnt;
    logic            r_match, r_dflt, r_err;
    logic [IDXW-1:0] r_m_idx, r_d_idx;

    logic w_start_ready, w_item_ready, w_res_valid;
    logic w_start_fire, w_item_fire;
    logic w_sel_bad, w_item_bad, w_hit;
    logic w_unused_flags;

    function automatic logic width_ok(input logic [WW-1:0] w);
        return (w != '0) && (int'(w) <= MAXW);
    endfunction

    // Mask to w bits, then fill the upper bits with the operand MSB only in a signed context.
    function automatic logic [MAXW-1:0] ext_val(input logic [MAXW-1:0] v,
                                                input logic [WW-1:0] w, input logic s);
        logic            msb;
        logic [MAXW-1:0] r;
        msb = 1'b0;
        for (int i = 0; i < MAXW; i++)
            if (i == int'(w) - 1) msb = v[i];
        for (int i = 0; i < MAXW; i++)
            r[i] = (i < int'(w)) ? v[i] : (s & msb);
        return r;
    endfunction

    function automatic logic eq_ctx(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                    input logic [WW-1:0] cw);
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < MAXW; i++)
            if ((i < int'(cw)) && (a[i] != b[i])) eq = 1'b0;
        return eq;
    endfunction

    assign w_start_fire = bus.start_valid && w_start_ready;
    assign w_item_fire  = bus.item_valid && w_item_ready;
    assign w_sel_bad    = !width_ok(bus.sel_width) || !width_ok(bus.ctx_width) ||
                          (bus.ctx_width < bus.sel_width);
    assign w_item_bad   = r_sel_bad || !width_ok(bus.item_width) || (r_ctx_w < bus.item_width);
    assign w_hit        = !bus.item_default && !w_item_bad &&
                          eq_ctx(ext_val(bus.item_value, bus.item_width, r_ctx_s), r_sel, r_ctx_w);
    // Declared signedness is only a driver-side cross-check; the context flag decides.
    assign w_unused_flags = bus.sel_signed ^ bus.item_signed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_start_ready = 1'b0;
        w_item_ready  = 1'b0;
        w_res_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_ready = 1'b1;
                if (bus.start_valid) w_next = SCAN;
            end
            SCAN: begin
                w_item_ready = 1'b1;
                if (bus.item_valid && bus.item_last) w_next = RESP;
            end
            RESP: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= '0;
            r_ctx_w   <= '0;
            r_ctx_s   <= 1'b0;
            r_sel_bad <= 1'b0;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_dflt    <= 1'b0;
            r_err     <= 1'b0;
            r_m_idx   <= '0;
            r_d_idx   <= '0;
        end else if (w_start_fire) begin
            r_sel     <= ext_val(bus.sel_value, bus.sel_width, bus.ctx_signed);
            r_ctx_w   <= bus.ctx_width;
            r_ctx_s   <= bus.ctx_signed;
            r_sel_bad <= w_sel_bad;
            r_err     <= w_sel_bad;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_dflt    <= 1'b0;
            r_m_idx   <= '0;
            r_d_idx   <= '0;
        end else if (w_item_fire) begin
            // The counter sticks at its ceiling; any beat seen there is one too many.
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            else             r_err <= 1'b1;
            if (!bus.item_default && w_item_bad) r_err <= 1'b1;
            if (w_hit && !r_match) begin
                r_match <= 1'b1;
                r_m_idx <= r_cnt;
            end
            if (bus.item_default && !r_dflt) begin
                r_dflt  <= 1'b1;
                r_d_idx <= r_cnt;
            end
        end
    end

    assign bus.start_ready = w_start_ready;
    assign bus.item_ready  = w_item_ready;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_match   = r_match;
    assign bus.res_dflt    = r_dflt && !r_match;
    assign bus.res_index   = r_match ? r_m_idx : (r_dflt ? r_d_idx : '0);
    assign bus.res_err     = r_err;
endmodule

// File: tb/tb_case_item_match_engine.sv
// Directed bench for case_item_match_engine: expected results are queued at stimulus time
// and a monitor compares them on each accepted result.
module tb_case_item_match_engine;
    typedef struct {
        logic       m;
        logic       d;
        logic [7:0] idx;
        logic       e;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    exp_t q[$];

    case_item_match_engine_if bus ();

    case_item_match_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic m, input logic d, input logic [7:0] idx, input logic e);
        exp_t x;
        x.m = m; x.d = d; x.idx = idx; x.e = e;
        q.push_back(x);
    endtask

    task automatic start_case(input logic [31:0] sv, input logic [5:0] sw, input logic ss,
                              input logic [5:0] cw, input logic cs);
        logic rdy;
        logic ok;
        ok = 1'b0;
        bus.sel_value   = sv;
        bus.sel_width   = sw;
        bus.sel_signed  = ss;
        bus.ctx_width   = cw;
        bus.ctx_signed  = cs;
        bus.start_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            rdy = bus.start_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        bus.start_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL start_timeout: got no start handshake expected one within 20 cycles");
        end
    endtask

    task automatic item(input logic [31:0] v, input logic [5:0] w, input logic s,
                        input logic d, input logic l);
        bus.item_value   = v;
        bus.item_width   = w;
        bus.item_signed  = s;
        bus.item_default = d;
        bus.item_last    = l;
        bus.item_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.item_valid = 1'b0;
        bus.item_last  = 1'b0;
    endtask

    // Monitor: compare each accepted result against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: got a result expected none");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_match", 32'(bus.res_match), 32'(e.m));
                chk("res_dflt",  32'(bus.res_dflt),  32'(e.d));
                chk("res_index", 32'(bus.res_index), 32'(e.idx));
                chk("res_err",   32'(bus.res_err),   32'(e.e));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.start_valid  = 1'b0;
        bus.sel_value    = '0;
        bus.sel_width    = '0;
        bus.sel_signed   = 1'b0;
        bus.ctx_width    = '0;
        bus.ctx_signed   = 1'b0;
        bus.item_valid   = 1'b0;
        bus.item_value   = '0;
        bus.item_width   = '0;
        bus.item_signed  = 1'b0;
        bus.item_default = 1'b0;
        bus.item_last    = 1'b0;
        bus.res_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_item_ready",  32'(bus.item_ready),  32'd0);
        chk("rst_res_valid",   32'(bus.res_valid),   32'd0);
        chk("rst_res_match",   32'(bus.res_match),   32'd0);
        chk("rst_res_index",   32'(bus.res_index),   32'd0);
        chk("rst_res_err",     32'(bus.res_err),     32'd0);

        // Item offered while idle must be ignored.
        item(32'h1, 6'd1, 1'b0, 1'b0, 1'b1);
        chk("idle_item_ignored", 32'(bus.start_ready), 32'd1);

        // 1: signed context, 1'sb1 sign-extends to 2'b11.
        start_case(32'h3, 6'd2, 1'b1, 6'd2, 1'b1);
        push(1'b1, 1'b0, 8'd1, 1'b0);
        item(32'h1, 6'd2, 1'b1, 1'b0, 1'b0);
        item(32'h1, 6'd1, 1'b1, 1'b0, 1'b1);

        // 2: unsigned context, 1'sb1 zero-extends to 2'b01 -> default at index 2.
        start_case(32'h3, 6'd2, 1'b1, 6'd2, 1'b0);
        push(1'b0, 1'b1, 8'd2, 1'b0);
        item(32'h0, 6'd1, 1'b0, 1'b0, 1'b0);
        item(32'h1, 6'd1, 1'b1, 1'b0, 1'b0);
        item(32'h0, 6'd0, 1'b0, 1'b1, 1'b1);

        // 3: no match, no default.
        start_case(32'h3, 6'd2, 1'b0, 6'd2, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b0);
        item(32'h0, 6'd1, 1'b1, 1'b0, 1'b0);
        item(32'h1, 6'd1, 1'b1, 1'b0, 1'b1);

        // 4: match at index 1, result held with res_ready low while a start is offered.
        start_case(32'h1, 6'd1, 1'b1, 6'd3, 1'b0);
        push(1'b1, 1'b0, 8'd1, 1'b0);
        bus.res_ready = 1'b0;
        item(32'h0, 6'd1, 1'b1, 1'b0, 1'b0);
        item(32'h1, 6'd1, 1'b0, 1'b0, 1'b0);
        item(32'h0, 6'd3, 1'b0, 1'b0, 1'b0);
        item(32'h0, 6'd0, 1'b0, 1'b1, 1'b1);
        bus.start_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_res_valid",   32'(bus.res_valid),   32'd1);
            chk("hold_res_match",   32'(bus.res_match),   32'd1);
            chk("hold_res_index",   32'(bus.res_index),   32'd1);
            chk("hold_start_ready", 32'(bus.start_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;

        // 5: default first, match at index 3 wins; later match at 4 ignored.
        start_case(32'hA, 6'd4, 1'b0, 6'd4, 1'b0);
        push(1'b1, 1'b0, 8'd3, 1'b0);
        item(32'h0, 6'd0, 1'b0, 1'b1, 1'b0);
        item(32'h3, 6'd4, 1'b0, 1'b0, 1'b0);
        item(32'h2, 6'd2, 1'b0, 1'b0, 1'b0);
        item(32'hA, 6'd4, 1'b0, 1'b0, 1'b0);
        item(32'hA, 6'd4, 1'b0, 1'b0, 1'b1);

        // Signed masking: bits above item_width ignored, 5'b10000 sign-extends to 8'hF0.
        start_case(32'hF0, 6'd8, 1'b1, 6'd8, 1'b1);
        push(1'b1, 1'b0, 8'd1, 1'b0);
        item(32'hFFFF_FFF0, 6'd4, 1'b1, 1'b0, 1'b0);
        item(32'h1234_5670, 6'd5, 1'b1, 1'b0, 1'b1);

        // Item wider than context: error, treated as non-match, scan continues.
        start_case(32'h1, 6'd2, 1'b0, 6'd2, 1'b0);
        push(1'b1, 1'b0, 8'd1, 1'b1);
        item(32'h1, 6'd3, 1'b0, 1'b0, 1'b0);
        item(32'h1, 6'd2, 1'b0, 1'b0, 1'b1);

        // 6: zero item width flags an error and cannot match.
        start_case(32'h0, 6'd2, 1'b0, 6'd2, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b1);
        item(32'h0, 6'd0, 1'b0, 1'b0, 1'b1);

        // Reset mid-SCAN.
        start_case(32'h0, 6'd2, 1'b0, 6'd2, 1'b0);
        item(32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("scan_rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("scan_rst_item_ready",  32'(bus.item_ready),  32'd0);
        chk("scan_rst_res_err",     32'(bus.res_err),     32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-RESP drops res_valid without a clock edge.
        bus.res_ready = 1'b0;
        start_case(32'h1, 6'd1, 1'b0, 6'd1, 1'b0);
        item(32'h1, 6'd1, 1'b0, 1'b0, 1'b1);
        chk("resp_valid_before_rst", 32'(bus.res_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("resp_rst_res_valid",   32'(bus.res_valid),   32'd0);
        chk("resp_rst_res_match",   32'(bus.res_match),   32'd0);
        chk("resp_rst_start_ready", 32'(bus.start_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset.
        start_case(32'h3, 6'd2, 1'b1, 6'd2, 1'b1);
        push(1'b1, 1'b0, 8'd1, 1'b0);
        item(32'h1, 6'd2, 1'b1, 1'b0, 1'b0);
        item(32'h1, 6'd1, 1'b1, 1'b0, 1'b1);

        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results outstanding expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
